// File: rtl/model_layer_node_unit_fp_mul_pipe_pkg.sv
// rtl/model_layer_node_unit_fp_mul_pipe_pkg.sv - shared constants, operand classes and flag indices
package fp_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;
    localparam int BIAS      = 2 ** (EXP_W_DEF - 1) - 1;
    localparam int W         = 1 + EXP_W_DEF + MAN_W_DEF;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W_DEF{1'b1}}, 1'b1, {(MAN_W_DEF-1){1'b0}}};

    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_SUB  = 3'd1,
        CLS_INF  = 3'd2,
        CLS_NAN  = 3'd3,
        CLS_NORM = 3'd4
    } fp_class_e;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_UNF  = 1;
    localparam int FLAG_OVF  = 2;
    localparam int FLAG_NAN  = 3;

endpackage

// File: rtl/model_layer_node_unit_fp_mul_pipe_classify.sv
// rtl/model_layer_node_unit_fp_mul_pipe_classify.sv - per-operand field split and class decode
module model_layer_node_unit_fp_classify
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] op_i,
    output logic [2:0]           cls_o,
    output logic                 sign_o,
    output logic [EXP_W-1:0]     exp_o,
    output logic [MAN_W:0]       man_o
);

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;
    logic             exp_zero;
    logic             exp_ones;
    logic             man_zero;
    fp_class_e        cls;

    assign sign_o   = op_i[EXP_W+MAN_W];
    assign exp_f    = op_i[EXP_W+MAN_W-1:MAN_W];
    assign man_f    = op_i[MAN_W-1:0];
    assign exp_zero = ~|exp_f;
    assign exp_ones = &exp_f;
    assign man_zero = ~|man_f;

    always_comb begin
        cls = CLS_NORM;
        if (exp_zero) begin
            cls = man_zero ? CLS_ZERO : CLS_SUB;
        end else if (exp_ones) begin
            cls = man_zero ? CLS_INF : CLS_NAN;
        end
    end

    assign cls_o = cls;
    assign exp_o = exp_f;
    // Hidden bit is only meaningful for normals; subnormals are flushed by the caller.
    assign man_o = {~exp_zero, man_f};

endmodule

// File: rtl/model_layer_node_unit_fp_mul_pipe.sv
// rtl/model_layer_node_unit_fp_mul_pipe.sv - 3-stage pipelined FP multiplier with valid/ready and tag
module model_layer_node_unit_fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int RNE   = 1,
    parameter int TAG_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     c,
    output logic [TAG_W-1:0]         out_tag,
    output logic [3:0]               flags
);

    localparam int WW = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int XW = EXP_W + 2;
    localparam logic [XW-1:0] BIAS_X = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
    localparam logic [WW-1:0] QNAN_W = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic en;

    logic [2:0]       cls_a, cls_b;
    logic             sgn_a, sgn_b;
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W:0]   man_a, man_b;

    logic                 s1_valid_q, s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q;
    logic [XW-1:0]        s1_exp_q;
    logic [PW-1:0]        s1_prod_q;
    logic [TAG_W-1:0]     s1_tag_q;
    logic                 s1_nan_d, s1_inf_d, s1_zero_d;
    logic [XW-1:0]        s1_exp_d;
    logic [PW-1:0]        s1_prod_d;

    logic                 s2_valid_q, s2_sign_q, s2_nan_q, s2_inf_q, s2_zero_q;
    logic                 s2_guard_q, s2_sticky_q;
    logic [XW-1:0]        s2_exp_q;
    logic [MAN_W-1:0]     s2_man_q;
    logic [TAG_W-1:0]     s2_tag_q;
    logic                 s2_guard_d, s2_sticky_d;
    logic [XW-1:0]        s2_exp_d;
    logic [MAN_W-1:0]     s2_man_d;

    logic                 out_valid_q;
    logic [WW-1:0]        c_q, c_d;
    logic [3:0]           flags_q, flags_d;
    logic [TAG_W-1:0]     tag_q;

    logic                 inc;
    logic                 carry;
    logic [MAN_W-1:0]     rman;
    logic signed [XW-1:0] fexp;

    assign en       = ~out_valid_q | out_ready;
    assign in_ready = en;

    model_layer_node_unit_fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .op_i   (a),
        .cls_o  (cls_a),
        .sign_o (sgn_a),
        .exp_o  (exp_a),
        .man_o  (man_a)
    );

    model_layer_node_unit_fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .op_i   (b),
        .cls_o  (cls_b),
        .sign_o (sgn_b),
        .exp_o  (exp_b),
        .man_o  (man_b)
    );

    // Stage 1: subnormals count as zero; zero x inf is folded into the NaN case here.
    always_comb begin
        logic za, zb, ia, ib;
        za        = (cls_a == CLS_ZERO) || (cls_a == CLS_SUB);
        zb        = (cls_b == CLS_ZERO) || (cls_b == CLS_SUB);
        ia        = (cls_a == CLS_INF);
        ib        = (cls_b == CLS_INF);
        s1_nan_d  = (cls_a == CLS_NAN) || (cls_b == CLS_NAN) || (za && ib) || (zb && ia);
        s1_inf_d  = ia || ib;
        s1_zero_d = za || zb;
        s1_exp_d  = XW'(exp_a) + XW'(exp_b) - BIAS_X;
        s1_prod_d = PW'(man_a) * PW'(man_b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_nan_q   <= 1'b0;
            s1_inf_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_prod_q  <= '0;
            s1_tag_q   <= '0;
        end else if (en) begin
            s1_valid_q <= in_valid;
            s1_sign_q  <= sgn_a ^ sgn_b;
            s1_nan_q   <= s1_nan_d;
            s1_inf_q   <= s1_inf_d;
            s1_zero_q  <= s1_zero_d;
            s1_exp_q   <= s1_exp_d;
            s1_prod_q  <= s1_prod_d;
            s1_tag_q   <= in_tag;
        end
    end

    // Stage 2: product of two [1,2) values lies in [1,4); normalise by at most one place.
    always_comb begin
        if (s1_prod_q[PW-1]) begin
            s2_exp_d    = s1_exp_q + XW'(1);
            s2_man_d    = s1_prod_q[PW-2 -: MAN_W];
            s2_guard_d  = s1_prod_q[MAN_W];
            s2_sticky_d = |s1_prod_q[MAN_W-1:0];
        end else begin
            s2_exp_d    = s1_exp_q;
            s2_man_d    = s1_prod_q[PW-3 -: MAN_W];
            s2_guard_d  = s1_prod_q[MAN_W-1];
            s2_sticky_d = |s1_prod_q[MAN_W-2:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_nan_q    <= 1'b0;
            s2_inf_q    <= 1'b0;
            s2_zero_q   <= 1'b0;
            s2_guard_q  <= 1'b0;
            s2_sticky_q <= 1'b0;
            s2_exp_q    <= '0;
            s2_man_q    <= '0;
            s2_tag_q    <= '0;
        end else if (en) begin
            s2_valid_q  <= s1_valid_q;
            s2_sign_q   <= s1_sign_q;
            s2_nan_q    <= s1_nan_q;
            s2_inf_q    <= s1_inf_q;
            s2_zero_q   <= s1_zero_q;
            s2_guard_q  <= s2_guard_d;
            s2_sticky_q <= s2_sticky_d;
            s2_exp_q    <= s2_exp_d;
            s2_man_q    <= s2_man_d;
            s2_tag_q    <= s1_tag_q;
        end
    end

    // Stage 3: round, then range-check the exponent that survives rounding.
    always_comb begin
        inc             = (RNE != 0) && s2_guard_q && (s2_sticky_q || s2_man_q[0]);
        {carry, rman}   = {1'b0, s2_man_q} + (MAN_W+1)'(inc);
        fexp            = s2_exp_q + XW'(carry);
        c_d             = {s2_sign_q, fexp[EXP_W-1:0], rman};
        flags_d         = 4'b0000;
        if (s2_nan_q) begin
            c_d                = QNAN_W;
            flags_d[FLAG_NAN]  = 1'b1;
        end else if (s2_inf_q) begin
            c_d                = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (s2_zero_q) begin
            c_d                = {s2_sign_q, {(EXP_W+MAN_W){1'b0}}};
            flags_d[FLAG_ZERO] = 1'b1;
        end else if (fexp >= EXP_MAX) begin
            c_d                = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_d[FLAG_OVF]  = 1'b1;
        end else if (fexp <= 0) begin
            c_d                = {s2_sign_q, {(EXP_W+MAN_W){1'b0}}};
            flags_d[FLAG_UNF]  = 1'b1;
            flags_d[FLAG_ZERO] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            c_q         <= '0;
            flags_q     <= '0;
            tag_q       <= '0;
        end else if (en) begin
            out_valid_q <= s2_valid_q;
            c_q         <= c_d;
            flags_q     <= flags_d;
            tag_q       <= s2_tag_q;
        end
    end

    assign out_valid = out_valid_q;
    assign c         = c_q;
    assign flags     = flags_q;
    assign out_tag   = tag_q;

endmodule
